// File: rtl/aes_key_pkg.sv
// aes_key_pkg: sizing functions, word helpers and FSM encoding shared by the AES key-expansion block
package aes_key_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_GEN,
        ST_SBOX,
        ST_DONE
    } key_state_e;

    function automatic int nk(input int key_bits);
        return key_bits / 32;
    endfunction

    function automatic int nr(input int key_bits);
        return nk(key_bits) + 6;
    endfunction

    function automatic int nw(input int key_bits);
        return 4 * (nr(key_bits) + 1);
    endfunction

    // GF(2^8) doubling; walks rcon through 01,02,..,80,1b,36
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [31:0] rot_word(input logic [31:0] w);
        return {w[23:0], w[31:24]};
    endfunction

    function automatic logic [31:0] rcon_word(input logic [7:0] rcon);
        return {rcon, 24'h000000};
    endfunction

endpackage

// File: rtl/key_word_store.sv
// key_word_store: expanded-key register file, bulk key load, one word write, two word reads, one round-key read
module key_word_store
    import aes_key_pkg::*;
#(
    parameter int KEY_BITS = 128,
    parameter int NK       = 4,
    parameter int NW       = 44,
    parameter int AW       = 6
) (
    input  logic                clk,
    input  logic                ld,
    input  logic [KEY_BITS-1:0] ld_key,
    input  logic                we,
    input  logic [AW-1:0]       wa,
    input  logic [31:0]         wd,
    input  logic [AW-1:0]       ra_prev,
    input  logic [AW-1:0]       ra_nk,
    input  logic [3:0]          rk_idx,
    output logic [31:0]         rd_prev,
    output logic [31:0]         rd_nk,
    output logic [127:0]        rk
);
    logic [31:0]   mem_q [NW];
    logic [AW-1:0] rk_base;

    // Key load fills W[0..NK-1] in one cycle; generated words arrive one at a time
    always_ff @(posedge clk) begin
        if (ld) begin
            for (int k = 0; k < NK; k++) mem_q[k] <= ld_key[KEY_BITS-1-32*k -: 32];
        end else if (we) begin
            mem_q[wa] <= wd;
        end
    end

    assign rk_base = AW'({rk_idx, 2'b00});
    assign rd_prev = mem_q[ra_prev];
    assign rd_nk   = mem_q[ra_nk];
    assign rk      = {mem_q[rk_base], mem_q[rk_base + AW'(1)], mem_q[rk_base + AW'(2)], mem_q[rk_base + AW'(3)]};

endmodule

// File: rtl/key_expand_param.sv
// key_expand_param: AES-128/192/256 key expansion, one round-key word per cycle via a shared external S-box
module key_expand_param
    import aes_key_pkg::*;
#(
    parameter int KEY_BITS = 128
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [KEY_BITS-1:0] key_in,
    input  logic                key_en,
    output logic                busy,
    output logic                key_done,
    output logic                s_rd_en,
    output logic [31:0]         s_in,
    input  logic [31:0]         s_out,
    input  logic                s_done,
    input  logic                key_rd_en,
    input  logic [3:0]          addr,
    output logic [127:0]        key_out,
    output logic                out_valid,
    output logic                addr_err
);
    localparam int NK = nk(KEY_BITS);
    localparam int NR = nr(KEY_BITS);
    localparam int NW = nw(KEY_BITS);
    localparam int AW = $clog2(NW);
    localparam logic [AW-1:0] LAST  = AW'(NW - 1);
    localparam logic [AW-1:0] NK_A  = AW'(NK);
    localparam logic [3:0]    NR_A  = 4'(NR);
    localparam logic [2:0]    NK_M1 = 3'(NK - 1);

    if (KEY_BITS != 128 && KEY_BITS != 192 && KEY_BITS != 256) begin : g_bad_key_bits
        $error("key_expand_param: KEY_BITS must be 128, 192 or 256");
    end

    key_state_e    state_q, state_d;
    logic [AW-1:0] i_q, i_d;
    logic [2:0]    j_q, j_d;
    logic [7:0]    rcon_q, rcon_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          s_rd_en_q, s_rd_en_d;
    logic [31:0]   s_in_q, s_in_d;
    logic [127:0]  key_out_q, key_out_d;
    logic          out_valid_q, out_valid_d;
    logic          addr_err_q, addr_err_d;

    logic [31:0]   prev_word, nk_word, w_new, up_temp;
    logic [127:0]  rk;
    logic          key_start, rd_ok, rd_bad, wr, last, up_sbox;
    logic [2:0]    j_nx, up_j;

    // j tracks i mod NK so the S-box decision needs no divider
    assign key_start = key_en && !busy_q;
    assign rd_ok     = key_rd_en && !busy_q && !key_en;
    assign rd_bad    = addr > NR_A;
    assign wr        = (state_q == ST_GEN) || (state_q == ST_SBOX && s_done);
    assign last      = i_q == LAST;
    assign w_new     = nk_word ^ ((state_q == ST_SBOX) ? (s_out ^ (j_q == 3'd0 ? rcon_word(rcon_q) : 32'h0)) : prev_word);
    assign j_nx      = (j_q == NK_M1) ? 3'd0 : j_q + 3'd1;
    // The word after the current one: from LOAD it is W[NK], otherwise W[i+1] whose temp is the word being written now
    assign up_j      = (state_q == ST_LOAD) ? j_q : j_nx;
    assign up_temp   = (state_q == ST_LOAD) ? prev_word : w_new;
    assign up_sbox   = (up_j == 3'd0) || (NK == 8 && up_j == 3'd4);

    key_word_store #(
        .KEY_BITS(KEY_BITS),
        .NK      (NK),
        .NW      (NW),
        .AW      (AW)
    ) u_store (
        .clk    (clk),
        .ld     (key_start),
        .ld_key (key_in),
        .we     (wr),
        .wa     (i_q),
        .wd     (w_new),
        .ra_prev(i_q - AW'(1)),
        .ra_nk  (i_q - NK_A),
        .rk_idx (rd_bad ? 4'd0 : addr),
        .rd_prev(prev_word),
        .rd_nk  (nk_word),
        .rk     (rk)
    );

    // Next-state: key load, word generation with S-box request set up one cycle ahead, round-key reads
    always_comb begin
        state_d     = state_q;
        i_d         = i_q;
        j_d         = j_q;
        rcon_d      = rcon_q;
        busy_d      = busy_q;
        done_d      = done_q;
        s_rd_en_d   = s_rd_en_q;
        s_in_d      = s_in_q;
        out_valid_d = rd_ok;
        addr_err_d  = rd_ok && rd_bad;
        key_out_d   = rd_ok ? (rd_bad ? '0 : rk) : key_out_q;
        if (key_start) begin
            state_d = ST_LOAD;
            i_d     = NK_A;
            j_d     = 3'd0;
            rcon_d  = 8'h01;
            busy_d  = 1'b1;
            done_d  = 1'b0;
        end else if (state_q == ST_LOAD || wr) begin
            if (wr && j_q == 3'd0) rcon_d = xtime(rcon_q);
            if (wr && last) begin
                state_d   = ST_DONE;
                busy_d    = 1'b0;
                done_d    = 1'b1;
                s_rd_en_d = 1'b0;
            end else begin
                state_d   = up_sbox ? ST_SBOX : ST_GEN;
                i_d       = wr ? i_q + AW'(1) : i_q;
                j_d       = up_j;
                s_rd_en_d = up_sbox;
                s_in_d    = up_sbox ? (up_j == 3'd0 ? rot_word(up_temp) : up_temp) : s_in_q;
            end
        end
    end

    // State registers; reset aborts any expansion at once
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            i_q         <= '0;
            j_q         <= '0;
            rcon_q      <= 8'h01;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            s_rd_en_q   <= 1'b0;
            s_in_q      <= '0;
            key_out_q   <= '0;
            out_valid_q <= 1'b0;
            addr_err_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            i_q         <= i_d;
            j_q         <= j_d;
            rcon_q      <= rcon_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            s_rd_en_q   <= s_rd_en_d;
            s_in_q      <= s_in_d;
            key_out_q   <= key_out_d;
            out_valid_q <= out_valid_d;
            addr_err_q  <= addr_err_d;
        end
    end

    assign busy      = busy_q;
    assign key_done  = done_q;
    assign s_rd_en   = s_rd_en_q;
    assign s_in      = s_in_q;
    assign key_out   = key_out_q;
    assign out_valid = out_valid_q;
    assign addr_err  = addr_err_q;

endmodule

// File: tb/tb_key_expand_param.sv
// tb_key_expand_param: scoreboard bench for AES-128/192/256 key expansion with an S-box responder model
module tb_key_expand_param;

    localparam logic [127:0] K1     = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] K1R1   = 128'ha0fafe1788542cb123a339392a6c7605;
    localparam logic [127:0] K1R2   = 128'hf2c295f27a96b9435935807a7359f67f;
    localparam logic [127:0] K1R10  = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    localparam logic [127:0] K2     = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] K2R1   = 128'hd6aa74fdd2af72fadaa678f1d6ab76fe;
    localparam logic [127:0] K2R10  = 128'h13111d7fe3944a17f307a78b4d2b30c5;
    localparam logic [191:0] K192   = 192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b;
    localparam logic [127:0] K192R0 = 128'h8e73b0f7da0e6452c810f32b809079e5;
    localparam logic [127:0] K192R12 = 128'he98ba06f448c773c8ecc720401002202;
    localparam logic [255:0] K256   = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;
    localparam logic [127:0] K256R1 = 128'h1f352c073b6108d72d9810a30914dff4;
    localparam logic [127:0] K256R2 = 128'h9ba354118e6925afa51a8b5f2067fcde;
    localparam logic [127:0] K256R14 = 128'hfe4890d1e6188d0b046df344706c631e;

    logic [2047:0] sbox_bits = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};

    typedef struct {
        int           u;
        logic [127:0] k;
        logic         e;
    } exp_t;

    logic         clk, rst;
    logic [127:0] key128;
    logic [3:0]   addr;
    logic         rnd;
    logic [2:0]   key_en_v, rd_en_v, busy_v, key_done_v, s_rd_en_v, s_done_v, out_valid_v, addr_err_v;
    logic [31:0]  s_in_v [3];
    logic [31:0]  s_out_v [3];
    logic [127:0] key_out_v [3];
    int           cnt [3] = '{0, 0, 0};
    int           dly [3] = '{0, 0, 0};
    int           req_n [3] = '{0, 0, 0};
    logic [2:0]   held = 3'b000;
    logic [31:0]  hold_in [3];
    logic [31:0]  sec_in = 32'h0;
    exp_t         sbq[$];
    exp_t         mon_e;
    int           n_tests = 0;
    int           n_fail = 0;

    key_expand_param #(.KEY_BITS(128)) u128 (
        .clk(clk), .rst(rst), .key_in(key128), .key_en(key_en_v[0]), .busy(busy_v[0]), .key_done(key_done_v[0]),
        .s_rd_en(s_rd_en_v[0]), .s_in(s_in_v[0]), .s_out(s_out_v[0]), .s_done(s_done_v[0]),
        .key_rd_en(rd_en_v[0]), .addr(addr), .key_out(key_out_v[0]), .out_valid(out_valid_v[0]), .addr_err(addr_err_v[0]));

    key_expand_param #(.KEY_BITS(192)) u192 (
        .clk(clk), .rst(rst), .key_in(K192), .key_en(key_en_v[1]), .busy(busy_v[1]), .key_done(key_done_v[1]),
        .s_rd_en(s_rd_en_v[1]), .s_in(s_in_v[1]), .s_out(s_out_v[1]), .s_done(s_done_v[1]),
        .key_rd_en(rd_en_v[1]), .addr(addr), .key_out(key_out_v[1]), .out_valid(out_valid_v[1]), .addr_err(addr_err_v[1]));

    key_expand_param #(.KEY_BITS(256)) u256 (
        .clk(clk), .rst(rst), .key_in(K256), .key_en(key_en_v[2]), .busy(busy_v[2]), .key_done(key_done_v[2]),
        .s_rd_en(s_rd_en_v[2]), .s_in(s_in_v[2]), .s_out(s_out_v[2]), .s_done(s_done_v[2]),
        .key_rd_en(rd_en_v[2]), .addr(addr), .key_out(key_out_v[2]), .out_valid(out_valid_v[2]), .addr_err(addr_err_v[2]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        logic [31:0] r;
        for (int k = 0; k < 4; k++) r[8*k +: 8] = sbox_bits[2047 - 8 * int'(w[8*k +: 8]) -: 8];
        return r;
    endfunction

    // S-box responder: answers after dly cycles, garbage on s_out while not done
    always_comb begin
        for (int u = 0; u < 3; u++) begin
            s_done_v[u] = s_rd_en_v[u] && (cnt[u] >= dly[u]);
            s_out_v[u]  = s_done_v[u] ? sub_word(s_in_v[u]) : 32'hdeadbeef;
        end
    end

    always @(posedge clk) begin
        for (int u = 0; u < 3; u++) begin
            held[u]    <= s_rd_en_v[u] && !s_done_v[u];
            hold_in[u] <= s_in_v[u];
            if (s_done_v[u]) begin
                cnt[u]   <= 0;
                dly[u]   <= rnd ? int'($urandom_range(5, 0)) : 0;
                req_n[u] <= req_n[u] + 1;
                if (u == 2 && req_n[u] == 1) sec_in <= s_in_v[u];
            end else begin
                cnt[u] <= s_rd_en_v[u] ? cnt[u] + 1 : 0;
            end
        end
    end

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Monitor: pops the scoreboard on every out_valid and checks request stability during S-box waits
    always @(negedge clk) begin
        for (int u = 0; u < 3; u++) begin
            if (held[u]) begin
                chk("sbox_hold_rd_en", 128'(s_rd_en_v[u]), 128'd1);
                chk("sbox_hold_s_in", 128'(s_in_v[u]), 128'(hold_in[u]));
            end
            if (out_valid_v[u]) begin
                if (sbq.size() == 0 || sbq[0].u != u) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL spurious_out_valid unit %0d: got key_out %h expected no output", u, key_out_v[u]);
                end else begin
                    mon_e = sbq.pop_front();
                    chk($sformatf("key_out_u%0d", u), key_out_v[u], mon_e.k);
                    chk($sformatf("addr_err_u%0d", u), 128'(addr_err_v[u]), 128'(mon_e.e));
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rd(input int u, input logic [3:0] a, input logic [127:0] k, input logic e);
        exp_t x;
        x.u = u;
        x.k = k;
        x.e = e;
        sbq.push_back(x);
        addr = a;
        rd_en_v[u] = 1'b1;
        tick();
        rd_en_v[u] = 1'b0;
    endtask

    task automatic expand(input int u, input int exp_cyc, input int brd, input bit with_rd);
        int c = 0;
        addr = 4'd1;
        key_en_v[u] = 1'b1;
        rd_en_v[u] = with_rd;
        tick();
        key_en_v[u] = 1'b0;
        rd_en_v[u] = 1'b0;
        chk("busy_after_key_en", 128'(busy_v[u]), 128'd1);
        chk("key_done_cleared", 128'(key_done_v[u]), 128'd0);
        chk("no_out_valid_on_key_en", 128'(out_valid_v[u]), 128'd0);
        while (!key_done_v[u] && c < 400) begin
            rd_en_v[u] = (c == brd);
            tick();
            rd_en_v[u] = 1'b0;
            if (c == brd) chk("read_while_busy_ignored", 128'(out_valid_v[u]), 128'd0);
            c++;
        end
        chk("key_done_set", 128'(key_done_v[u]), 128'd1);
        chk("busy_cleared", 128'(busy_v[u]), 128'd0);
        if (exp_cyc > 0) chk("latency", 128'(c), 128'(exp_cyc));
    endtask

    initial begin
        rst = 1'b1;
        rnd = 1'b0;
        key128 = K1;
        addr = 4'd0;
        key_en_v = 3'b000;
        rd_en_v = 3'b000;
        #2 rst = 1'b0;
        tick();
        tick();
        for (int u = 0; u < 3; u++) begin
            chk("reset_busy", 128'(busy_v[u]), 128'd0);
            chk("reset_key_done", 128'(key_done_v[u]), 128'd0);
            chk("reset_s_rd_en", 128'(s_rd_en_v[u]), 128'd0);
            chk("reset_out_valid", 128'(out_valid_v[u]), 128'd0);
            chk("reset_addr_err", 128'(addr_err_v[u]), 128'd0);
        end
        chk("reset_s_in", 128'(s_in_v[0]), 128'd0);
        chk("reset_key_out", key_out_v[0], 128'd0);
        rst = 1'b1;
        tick();

        expand(0, 41, 5, 1'b0);
        rd(0, 4'd0, K1, 1'b0);
        rd(0, 4'd1, K1R1, 1'b0);
        rd(0, 4'd2, K1R2, 1'b0);
        rd(0, 4'd10, K1R10, 1'b0);
        rd(0, 4'd11, 128'd0, 1'b1);
        rd(0, 4'd15, 128'd0, 1'b1);
        rd(0, 4'd10, K1R10, 1'b0);
        tick();
        tick();
        chk("out_valid_pulse", 128'(out_valid_v[0]), 128'd0);
        chk("key_out_hold", key_out_v[0], K1R10);

        expand(0, 41, -1, 1'b1);
        rd(0, 4'd1, K1R1, 1'b0);

        key128 = K2;
        key_en_v[0] = 1'b1;
        tick();
        key_en_v[0] = 1'b0;
        repeat (17) tick();
        chk("sbox_req_before_abort", 128'(s_rd_en_v[0]), 128'd1);
        rst = 1'b0;
        #1;
        chk("abort_s_rd_en", 128'(s_rd_en_v[0]), 128'd0);
        chk("abort_busy", 128'(busy_v[0]), 128'd0);
        chk("abort_key_done", 128'(key_done_v[0]), 128'd0);
        tick();
        rst = 1'b1;
        tick();
        expand(0, 41, -1, 1'b0);
        rd(0, 4'd1, K2R1, 1'b0);
        rd(0, 4'd10, K2R10, 1'b0);

        expand(1, 47, -1, 1'b0);
        rd(1, 4'd0, K192R0, 1'b0);
        rd(1, 4'd12, K192R12, 1'b0);
        rd(1, 4'd13, 128'd0, 1'b1);
        chk("sbox_requests_192", 128'(req_n[1]), 128'd8);

        expand(2, 53, -1, 1'b0);
        rd(2, 4'd1, K256R1, 1'b0);
        rd(2, 4'd2, K256R2, 1'b0);
        rd(2, 4'd14, K256R14, 1'b0);
        rd(2, 4'd15, 128'd0, 1'b1);
        chk("sbox_requests_256", 128'(req_n[2]), 128'd13);
        chk("subword_no_rot_256", 128'(sec_in), 128'h2067fcde);

        rnd = 1'b1;
        key128 = K1;
        expand(0, 0, -1, 1'b0);
        rd(0, 4'd1, K1R1, 1'b0);
        rd(0, 4'd2, K1R2, 1'b0);
        rd(0, 4'd10, K1R10, 1'b0);
        tick();
        tick();
        chk("scoreboard_drained", 128'(sbq.size()), 128'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/key_expand_param.md
Name: key_expand_param

Overview:
Parametrised AES key-expansion engine covering AES-128, AES-192 and AES-256, selected at elaboration by KEY_BITS. It takes a cipher key and generates all round-key words one word per cycle. SubWord goes through the shared external 4-byte S-box using the existing s_rd_en/s_done handshake. Rcon is computed internally. The block sits between the key-load interface and the round datapath, which reads 128-bit round keys by round index.

Parameters:
KEY_BITS, 128, cipher key length; legal values 128, 192, 256, anything else is an elaboration error.
NK (derived), KEY_BITS/32, key words: 4, 6 or 8.
NR (derived), NK+6, round count: 10, 12 or 14.
NW (derived), 4*(NR+1), stored words: 44, 52 or 60.

Ports:
clk  in  1  clock; all state updates on rising edge.
rst  in  1  asynchronous, active-low reset.
key_in  in  KEY_BITS  cipher key; byte 0 is in bits [KEY_BITS-1:KEY_BITS-8].
key_en  in  1  start pulse; samples key_in; ignored while busy.
busy  out  1  high from the cycle after an accepted key_en until the last word is written.
key_done  out  1  sticky; set when expansion completes, cleared by accepted key_en or by rst.
s_rd_en  out  1  S-box request.
s_in  out  32  S-box input word; byte 0 in MSBs.
s_out  in  32  S-box result word.
s_done  in  1  S-box result valid; may be high in the same cycle as s_rd_en.
key_rd_en  in  1  round-key read request.
addr  in  4  round index, 0..NR.
key_out  out  128  round key addr = words 4*addr..4*addr+3; word 4*addr in [127:96].
out_valid  out  1  pulses one cycle after an accepted read.
addr_err  out  1  pulses one cycle after a read with addr>NR.

Behaviour:
- Reset (rst low, asynchronous): state IDLE; busy, key_done, s_rd_en, out_valid and addr_err are 0; s_in and key_out are 0; rcon is 0x01; word index is 0. Word storage is not reset. key_done=0 guarantees no stale keys are used.
- FSM states: IDLE, LOAD, GEN, SBOX, DONE.
- IDLE/DONE + key_en: latch key_in into W[0..NK-1], rcon=0x01, i=NK, clear key_done, go to GEN. LOAD is that single cycle.
- GEN computes word i from temp=W[i-1]:
  - i%NK==0: temp = SubWord(RotWord(temp)) ^ {rcon,24'h0}. Needs the S-box.
  - NK==8 and i%NK==4: temp = SubWord(temp). Needs the S-box.
  - Otherwise no S-box; write W[i]=W[i-NK]^temp in the same cycle.
- S-box word: enter SBOX, drive s_in (RotWord applied when required) and s_rd_en=1, and hold both until s_done is sampled 1. In the s_done cycle write W[i] = W[i-NK] ^ s_out ^ rcon term. s_rd_en drops the next cycle.
- After each rcon use: rcon = {rcon[6:0],1'b0} ^ (rcon[7] ? 8'h1b : 0). Sequence 01,02,04,..,80,1b,36.
- After W[NW-1] is written: busy=0 and key_done=1 on the next cycle; go to DONE.
- Latency with zero-wait S-box (s_done tied to s_rd_en): 1 load cycle + (NW-NK) word cycles. AES-128 gives key_done 41 cycles after key_en. Each S-box wait cycle adds 1.
- Reads are accepted only when key_rd_en=1 and busy=0:
  - key_out is registered; out_valid=1 one cycle later.
  - addr>NR: key_out=0, out_valid=1 and addr_err=1 for one cycle.
  - Read while busy: ignored, out_valid stays 0.
  - key_out holds its value between reads.
- Simultaneous key_en and key_rd_en in IDLE/DONE: key_en wins and the read is dropped.
- key_en while busy: ignored, no state change.
- Reset mid-expansion: immediate abort to IDLE, s_rd_en=0 asynchronously, key_done=0.

Decomposition:
- Package aes_key_pkg holds:
  - functions nk(), nr(), nw();
  - xtime() for rcon;
  - RotWord/word-XOR helpers;
  - the FSM state enum.
- One sub-module, key_word_store: NW x 32 register file with one write port and two read ports (W[i-1], W[i-NK]) plus a 4-word round-key read.

Test Plan:
- AES-128 key 2b7e151628aed2a6abf7158809cf4f3c, zero-wait S-box -> key_done at cycle 41; round 1 = a0fafe1788542cb123a339392a6c7605; round 10 = d014f9a8c9ee2589e13f0cc8b6630ca6.
- AES-192 key 8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b -> round 12 = e98ba06f448c773c8ecc720401002202; exactly 8 S-box requests.
- AES-256 key 603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4 -> round 14 = fe4890d1e6188d0b046df344706c631e; 13 S-box requests, non-RotWord SubWord at i%8==4.
- S-box with random 0-5 cycle s_done delay -> s_rd_en and s_in stable until s_done; results identical to the zero-wait run.
- Read while busy, read with addr=15, and key_en with key_rd_en together -> no out_valid; addr_err pulse with key_out=0; key_en wins.
- rst low at word 20, then new key_en -> s_rd_en=0 immediately; key_done=0; the second key expands correctly.
